// File: rtl/stream_frame_gen_if.sv
// Stream bundle carrying the framed test data from the generator to a link TX sink.
interface stream_frame_gen_if #(
  parameter int DW = 16
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (
    output tdata,
    output tkeep,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tkeep,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/stream_frame_gen.sv
// Test-frame source for link bring-up: emits frames of configurable length with an
// optional idle gap and a selectable payload (fixed pattern, beat counter, LFSR or
// sequence header). Payload state only advances when a beat is accepted by the sink,
// so backpressure never drops or duplicates data.
module stream_frame_gen #(
  parameter int          DW      = 16,
  parameter int          PW      = 128,
  parameter logic [PW-1:0] PATTERN = 128'h0123_3210_2222_3333_4444_5555_beaf_dead,
  parameter int          LW      = 12,
  parameter logic [31:0] SEED    = 32'hACE1_2468
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic [LW-1:0]            frame_len,
  input  logic [LW-1:0]            gap_len,
  input  logic [1:0]               mode,
  stream_frame_gen_if.master       stream_tx,
  output logic [15:0]              frame_cnt,
  output logic                     busy
);

  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 in right-shift form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] gap_q, gap_d;
  logic [1:0]    mode_q, mode_d;
  logic [LW-1:0] beatCnt_q, beatCnt_d;
  logic [LW-1:0] gapCnt_q, gapCnt_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [31:0]   lfsr_q, lfsr_d;
  logic [15:0]   frameCnt_q, frameCnt_d;

  logic          validOut;
  logic          lastBeat;
  logic          xfer;
  logic          relatch;
  logic [LW-1:0] startLen;

  function automatic logic [31:0] lfsrStep(input logic [31:0] cur);
    lfsrStep = {1'b0, cur[31:1]} ^ (cur[0] ? LFSR_TAPS : 32'h0);
  endfunction

  assign validOut = (state_q == SEND);
  assign lastBeat = (beatCnt_q == (len_q - LW'(1)));
  assign xfer     = validOut && stream_tx.tready;
  assign startLen = (frame_len == '0) ? LW'(1) : frame_len;

  // State register plus all latched config and payload state; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_q      <= LW'(1);
      gap_q      <= '0;
      mode_q     <= '0;
      beatCnt_q  <= '0;
      gapCnt_q   <= '0;
      pat_q      <= PATTERN;
      lfsr_q     <= SEED;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      gap_q      <= gap_d;
      mode_q     <= mode_d;
      beatCnt_q  <= beatCnt_d;
      gapCnt_q   <= gapCnt_d;
      pat_q      <= pat_d;
      lfsr_q     <= lfsr_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  // Next-state logic: a frame start (from IDLE, end of GAP, or a back-to-back tlast) relatches config.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    gap_d      = gap_q;
    mode_d     = mode_q;
    beatCnt_d  = beatCnt_q;
    gapCnt_d   = gapCnt_q;
    pat_d      = pat_q;
    lfsr_d     = lfsr_q;
    frameCnt_d = frameCnt_q;
    relatch    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          relatch = 1'b1;
        end
      end
      SEND: begin
        if (xfer) begin
          beatCnt_d = beatCnt_q + LW'(1);
          pat_d     = {pat_q[DW-1:0], pat_q[PW-1:DW]};
          if (mode_q == 2'd2) begin
            lfsr_d = lfsrStep(lfsr_q);
          end
          if (lastBeat) begin
            frameCnt_d = frameCnt_q + 16'd1;
            if (gap_q != '0) begin
              state_d  = GAP;
              gapCnt_d = gap_q - LW'(1);
            end else if (enable) begin
              relatch = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (gapCnt_q == '0) begin
          if (enable) begin
            relatch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gapCnt_d = gapCnt_q - LW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (relatch) begin
      state_d   = SEND;
      len_d     = startLen;
      gap_d     = gap_len;
      mode_d    = mode;
      beatCnt_d = '0;
      pat_d     = PATTERN;
    end
  end

  // Beat payload is a pure function of registered state, so it holds steady while stalled.
  always_comb begin
    stream_tx.tdata = '0;
    if (validOut) begin
      case (mode_q)
        2'd0:    stream_tx.tdata = pat_q[DW-1:0];
        2'd1:    stream_tx.tdata = DW'(beatCnt_q);
        2'd2:    stream_tx.tdata = lfsr_q[DW-1:0];
        default: stream_tx.tdata = (beatCnt_q == '0) ? DW'(frameCnt_q) : DW'(beatCnt_q);
      endcase
    end
  end

  assign stream_tx.tvalid = validOut;
  assign stream_tx.tlast  = validOut && lastBeat;
  assign stream_tx.tkeep  = '1;
  assign frame_cnt        = frameCnt_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_stream_frame_gen.sv
// Directed bench for stream_frame_gen: each scenario drives config, collects accepted
// beats from the stream and compares them with hand-derived expected sequences.
module tb_stream_frame_gen;

  localparam int          DW   = 16;
  localparam int          LW   = 12;
  localparam logic [31:0] SEED = 32'hACE1_2468;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [LW-1:0] frameLen;
  logic [LW-1:0] gapLen;
  logic [1:0]    mode;
  logic [15:0]   frameCnt;
  logic          busy;

  stream_frame_gen_if #(.DW(DW)) streamTx ();

  stream_frame_gen #(
    .DW  (DW),
    .LW  (LW),
    .SEED(SEED)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .frame_len(frameLen),
    .gap_len  (gapLen),
    .mode     (mode),
    .stream_tx(streamTx),
    .frame_cnt(frameCnt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] dataQ[$];
  logic          lastQ[$];
  logic          prevStall = 1'b0;
  logic [DW-1:0] prevData  = '0;
  logic          prevLast  = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample the stream mid-cycle: record beats that will transfer at the next edge and
  // confirm a stalled beat is still offered unchanged.
  always @(negedge clk) begin
    if (!reset_n) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stallValid", 32'(streamTx.tvalid), 32'd1);
        checkOutput("stallData", 32'(streamTx.tdata), 32'(prevData));
        checkOutput("stallLast", 32'(streamTx.tlast), 32'(prevLast));
      end
      if (streamTx.tvalid && streamTx.tready) begin
        dataQ.push_back(streamTx.tdata);
        lastQ.push_back(streamTx.tlast);
      end
      prevStall = streamTx.tvalid && !streamTx.tready;
      prevData  = streamTx.tdata;
      prevLast  = streamTx.tlast;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [1:0] md,
                               input logic [LW-1:0] fl, input logic [LW-1:0] gl);
    enable   = en;
    mode     = md;
    frameLen = fl;
    gapLen   = gl;
  endtask

  task automatic doReset();
    reset_n          = 1'b0;
    enable           = 1'b0;
    streamTx.tready  = 1'b1;
    repeat (2) cycle();
    reset_n = 1'b1;
    dataQ.delete();
    lastQ.delete();
  endtask

  task automatic waitBeats(input int n, input int budget);
    int c = 0;
    while (dataQ.size() < n && c < budget) begin
      cycle();
      c++;
    end
    if (dataQ.size() < n) checkOutput("beatTimeout", 32'(dataQ.size()), 32'(n));
  endtask

  task automatic waitIdle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      cycle();
      c++;
    end
    if (busy) checkOutput("idleTimeout", 32'(busy), 32'd0);
  endtask

  function automatic logic [31:0] refLfsr(input logic [31:0] cur);
    logic [31:0] taps;
    taps = (32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1;
    refLfsr = cur[0] ? ((cur >> 1) ^ taps) : (cur >> 1);
  endfunction

  initial begin
    logic [15:0] patExp[10];
    logic [15:0] readyPat;
    logic [31:0] lfsrRef;

    patExp   = '{16'hdead, 16'hbeaf, 16'h5555, 16'h4444, 16'h3333,
                 16'h2222, 16'h3210, 16'h0123, 16'hdead, 16'hbeaf};
    readyPat = 16'b1011_0010_1001_1001;

    // Reset values while reset_n is held low
    reset_n         = 1'b0;
    streamTx.tready = 1'b1;
    applyStimulus(1'b0, 2'd0, '0, '0);
    repeat (2) cycle();
    checkOutput("rstValid", 32'(streamTx.tvalid), 32'd0);
    checkOutput("rstLast", 32'(streamTx.tlast), 32'd0);
    checkOutput("rstData", 32'(streamTx.tdata), 32'd0);
    checkOutput("rstFrameCnt", 32'(frameCnt), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstKeep", 32'(streamTx.tkeep), 32'h3);

    // Counter mode, 4-beat frames back-to-back: 12 beats in exactly 12 cycles
    doReset();
    applyStimulus(1'b1, 2'd1, 12'd4, 12'd0);
    cycle();
    checkOutput("t1Latency", 32'(streamTx.tvalid), 32'd1);
    waitBeats(12, 12);
    checkOutput("t1FrameCnt", 32'(frameCnt), 32'd3);
    enable = 1'b0;
    waitIdle(20);
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("t1Data%0d", i), 32'(dataQ[i]), 32'(i % 4));
      checkOutput($sformatf("t1Last%0d", i), 32'(lastQ[i]), 32'((i % 4) == 3));
    end
    checkOutput("t1FrameCntEnd", 32'(frameCnt), 32'd4);

    // Pattern mode, 10-beat frames: pointer wraps after 8 beats and restarts per frame
    doReset();
    applyStimulus(1'b1, 2'd0, 12'd10, 12'd0);
    cycle();
    waitBeats(11, 11);
    enable = 1'b0;
    waitIdle(30);
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("t2Data%0d", i), 32'(dataQ[i]), 32'(patExp[i % 10]));
      checkOutput($sformatf("t2Last%0d", i), 32'(lastQ[i]), 32'(i == 9));
    end

    // Counter mode, 6-beat frame under irregular backpressure
    doReset();
    applyStimulus(1'b1, 2'd1, 12'd6, 12'd0);
    cycle();
    enable = 1'b0;
    for (int k = 0; k < 200 && busy; k++) begin
      streamTx.tready = readyPat[k % 16];
      cycle();
    end
    streamTx.tready = 1'b1;
    checkOutput("t3Idle", 32'(busy), 32'd0);
    checkOutput("t3Count", 32'(dataQ.size()), 32'd6);
    for (int i = 0; i < 6 && i < dataQ.size(); i++) begin
      checkOutput($sformatf("t3Data%0d", i), 32'(dataQ[i]), 32'(i));
      checkOutput($sformatf("t3Last%0d", i), 32'(lastQ[i]), 32'(i == 5));
    end

    // Two-beat frames with a three-cycle gap: valid pattern 1,1,0,0,0 and busy held high
    doReset();
    applyStimulus(1'b1, 2'd1, 12'd2, 12'd3);
    cycle();
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("t4Valid%0d", i), 32'(streamTx.tvalid), 32'((i % 5) < 2));
      checkOutput($sformatf("t4Busy%0d", i), 32'(busy), 32'd1);
      cycle();
    end
    enable = 1'b0;
    waitIdle(20);
    checkOutput("t4BusyEnd", 32'(busy), 32'd0);

    // Enable dropped after beat 1 of an 8-beat frame: the frame still completes
    doReset();
    applyStimulus(1'b1, 2'd1, 12'd8, 12'd0);
    cycle();
    waitBeats(2, 2);
    enable = 1'b0;
    waitIdle(20);
    checkOutput("t5Count", 32'(dataQ.size()), 32'd8);
    for (int i = 0; i < 8 && i < dataQ.size(); i++) begin
      checkOutput($sformatf("t5Data%0d", i), 32'(dataQ[i]), 32'(i));
      checkOutput($sformatf("t5Last%0d", i), 32'(lastQ[i]), 32'(i == 7));
    end
    checkOutput("t5Busy", 32'(busy), 32'd0);
    checkOutput("t5Valid", 32'(streamTx.tvalid), 32'd0);
    checkOutput("t5FrameCnt", 32'(frameCnt), 32'd1);

    // Zero frame length behaves as single-beat frames
    doReset();
    applyStimulus(1'b1, 2'd1, 12'd0, 12'd0);
    cycle();
    waitBeats(3, 3);
    enable = 1'b0;
    waitIdle(10);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6Data%0d", i), 32'(dataQ[i]), 32'd0);
      checkOutput($sformatf("t6Last%0d", i), 32'(lastQ[i]), 32'd1);
    end

    // LFSR mode across two frames: sequence continues without reloading between frames
    doReset();
    applyStimulus(1'b1, 2'd2, 12'd4, 12'd0);
    cycle();
    waitBeats(6, 6);
    enable = 1'b0;
    waitIdle(20);
    checkOutput("t7Count", 32'(dataQ.size()), 32'd8);
    lfsrRef = SEED;
    for (int i = 0; i < 8 && i < dataQ.size(); i++) begin
      checkOutput($sformatf("t7Data%0d", i), 32'(dataQ[i]), 32'(lfsrRef[DW-1:0]));
      lfsrRef = refLfsr(lfsrRef);
    end

    // Sequence-header mode: beat 0 carries the running frame count
    doReset();
    applyStimulus(1'b1, 2'd3, 12'd3, 12'd1);
    cycle();
    waitBeats(9, 40);
    enable = 1'b0;
    waitIdle(20);
    for (int i = 0; i < 9 && i < dataQ.size(); i++) begin
      checkOutput($sformatf("t8Data%0d", i), 32'(dataQ[i]),
                  ((i % 3) == 0) ? 32'(i / 3) : 32'(i % 3));
      checkOutput($sformatf("t8Last%0d", i), 32'(lastQ[i]), 32'((i % 3) == 2));
    end

    // Reset pulsed mid-frame aborts immediately and clears the frame count
    doReset();
    applyStimulus(1'b1, 2'd1, 12'd2, 12'd0);
    cycle();
    waitBeats(5, 5);
    checkOutput("t9FrameCntPre", 32'(frameCnt), 32'd2);
    checkOutput("t9BusyPre", 32'(busy), 32'd1);
    reset_n = 1'b0;
    cycle();
    checkOutput("t9Valid", 32'(streamTx.tvalid), 32'd0);
    checkOutput("t9Last", 32'(streamTx.tlast), 32'd0);
    checkOutput("t9Data", 32'(streamTx.tdata), 32'd0);
    checkOutput("t9FrameCnt", 32'(frameCnt), 32'd0);
    checkOutput("t9Busy", 32'(busy), 32'd0);
    enable  = 1'b0;
    reset_n = 1'b1;
    cycle();
    checkOutput("t9BusyAfter", 32'(busy), 32'd0);
    checkOutput("t9ValidAfter", 32'(streamTx.tvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
